// File: rtl/random_draw_ctrl.sv
// Deck-draw controller in front of the 3-bit random source.
// Each draw requests samples from the source and rejects cards that are
// already drawn. After P_MAX_RETRY rejections it takes the lowest free card
// instead, so a full deck of six draws returns every card 0..5 exactly once.
module random_draw_ctrl #(
  parameter int P_RETRY_GAP = 3,
  parameter int P_MAX_RETRY = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_draw,
  input  logic       i_clear,
  output logic       o_rng_start,
  input  logic [2:0] i_rng_value,
  output logic       o_valid,
  output logic [2:0] o_value,
  output logic       o_busy,
  output logic [2:0] o_remaining,
  output logic       o_empty,
  output logic       o_fallback
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SAMPLE,
    S_GAP,
    S_FALLBACK
  } state_t;

  // Gap counter is loaded with one less than the gap because S_GAP itself
  // counts as a cycle; the retry limit is compared against its last index.
  localparam logic [3:0] GAP_LOAD   = 4'(P_RETRY_GAP - 1);
  localparam logic [3:0] RETRY_LAST = 4'(P_MAX_RETRY - 1);

  state_t     state, state_nxt;
  logic [5:0] mask, mask_nxt;
  logic [3:0] retry, retry_nxt;
  logic [3:0] gap, gap_nxt;
  logic [2:0] value_nxt;
  logic [2:0] remaining_nxt;
  logic       valid_nxt;
  logic       fallback_nxt;
  logic [2:0] sample;
  logic [2:0] pick;

  // Source values 5, 6 and 7 all map onto card 5.
  function automatic logic [2:0] clamp_card(input logic [2:0] v);
    return (v >= 3'd5) ? 3'd5 : v;
  endfunction

  // Lowest card index whose used bit is still clear.
  function automatic logic [2:0] lowest_free(input logic [5:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (!m[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign sample = clamp_card(i_rng_value);
  assign pick   = (state == S_FALLBACK) ? lowest_free(mask) : sample;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic plus the next values of the deck, counters and outputs.
  always_comb begin
    state_nxt     = state;
    mask_nxt      = mask;
    retry_nxt     = retry;
    gap_nxt       = gap;
    value_nxt     = o_value;
    remaining_nxt = o_remaining;
    valid_nxt     = 1'b0;
    fallback_nxt  = 1'b0;
    if (i_clear) begin
      state_nxt     = S_IDLE;
      mask_nxt      = 6'b0;
      remaining_nxt = 3'd6;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_draw && !o_empty) begin
            state_nxt = S_REQ;
            retry_nxt = 4'd0;
          end
        end
        S_REQ: state_nxt = S_SAMPLE;
        S_SAMPLE, S_FALLBACK: begin
          if (state == S_FALLBACK || !mask[pick]) begin
            mask_nxt[pick] = 1'b1;
            value_nxt      = pick;
            valid_nxt      = 1'b1;
            fallback_nxt   = (state == S_FALLBACK);
            remaining_nxt  = (o_remaining != 3'd0) ? o_remaining - 3'd1 : 3'd0;
            state_nxt      = S_IDLE;
          end else if (retry < RETRY_LAST) begin
            retry_nxt = retry + 4'd1;
            gap_nxt   = GAP_LOAD;
            state_nxt = S_GAP;
          end else begin
            state_nxt = S_FALLBACK;
          end
        end
        S_GAP: begin
          if (gap == 4'd0) state_nxt = S_REQ;
          else             gap_nxt   = gap - 4'd1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Deck, counters and registered outputs; flags are derived from next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask        <= 6'b0;
      retry       <= 4'd0;
      gap         <= 4'd0;
      o_value     <= 3'd0;
      o_valid     <= 1'b0;
      o_fallback  <= 1'b0;
      o_remaining <= 3'd6;
      o_empty     <= 1'b0;
      o_rng_start <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      mask        <= mask_nxt;
      retry       <= retry_nxt;
      gap         <= gap_nxt;
      o_value     <= value_nxt;
      o_valid     <= valid_nxt;
      o_fallback  <= fallback_nxt;
      o_remaining <= remaining_nxt;
      o_empty     <= (remaining_nxt == 3'd0);
      o_rng_start <= (state_nxt == S_REQ);
      o_busy      <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_random_draw_ctrl.sv
// Directed bench for random_draw_ctrl with a scripted random source.
module tb_random_draw_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       draw = 1'b0;
  logic       clear = 1'b0;
  logic       rng_start;
  logic [2:0] rng_value = 3'd0;
  logic       valid;
  logic [2:0] value;
  logic       busy;
  logic [2:0] remaining;
  logic       empty;
  logic       fallback;

  random_draw_ctrl #(.P_RETRY_GAP(3), .P_MAX_RETRY(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_draw      (draw),
    .i_clear     (clear),
    .o_rng_start (rng_start),
    .i_rng_value (rng_value),
    .o_valid     (valid),
    .o_value     (value),
    .o_busy      (busy),
    .o_remaining (remaining),
    .o_empty     (empty),
    .o_fallback  (fallback)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scripted source: up to four answers, the last one repeats.
  logic [11:0] rng_cur = 12'd0;
  int ridx = 0;
  int start_cnt = 0;
  int first_start = 0;
  int second_start = 0;

  // Answer each start pulse with the next scripted value for the following cycle.
  always @(negedge clk) begin
    if (rng_start) begin
      if (start_cnt == 0) first_start = cyc;
      else if (start_cnt == 1) second_start = cyc;
      start_cnt = start_cnt + 1;
      rng_value = rng_cur[3*ridx +: 3];
      if (ridx < 3) ridx = ridx + 1;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        clr;
    logic [11:0] rng;
    logic [2:0]  val;
    logic        fb;
    int          pulses;
    int          lat;
    int          gap;
    logic [2:0]  rem;
    logic        emp;
  } vec_t;

  vec_t tbl[16];
  int   n_vec;

  task automatic run_draw(input vec_t v, input int k);
    int t0;
    int n;
    rng_cur   = v.rng;
    ridx      = 0;
    start_cnt = 0;
    @(negedge clk);
    draw = 1'b1;
    t0 = cyc;
    @(negedge clk);
    draw = 1'b0;
    n = 0;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_got_valid", k), int'(valid), 1);
    check($sformatf("v%0d_value", k), int'(value), int'(v.val));
    check($sformatf("v%0d_fallback", k), int'(fallback), int'(v.fb));
    check($sformatf("v%0d_pulses", k), start_cnt, v.pulses);
    check($sformatf("v%0d_latency", k), cyc - t0, v.lat);
    check($sformatf("v%0d_remaining", k), int'(remaining), int'(v.rem));
    check($sformatf("v%0d_empty", k), int'(empty), int'(v.emp));
    check($sformatf("v%0d_busy", k), int'(busy), 0);
    if (v.gap != 0) check($sformatf("v%0d_start_gap", k), second_start - first_start, v.gap);
    @(negedge clk);
    check($sformatf("v%0d_valid_pulse", k), int'(valid), 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int nv;
    // clr, rng {v3,v2,v1,v0}, val, fb, pulses, lat, gap, rem, emp
    tbl[0]  = '{1'b0, {3'd3, 3'd3, 3'd3, 3'd3}, 3'd3, 1'b0, 1, 3, 0, 3'd5, 1'b0};
    tbl[1]  = '{1'b0, {3'd1, 3'd1, 3'd1, 3'd3}, 3'd1, 1'b0, 2, 8, 5, 3'd4, 1'b0};
    tbl[2]  = '{1'b0, {3'd7, 3'd7, 3'd7, 3'd7}, 3'd5, 1'b0, 1, 3, 0, 3'd3, 1'b0};
    tbl[3]  = '{1'b0, {3'd0, 3'd0, 3'd0, 3'd6}, 3'd0, 1'b0, 2, 8, 5, 3'd2, 1'b0};
    tbl[4]  = '{1'b0, {3'd0, 3'd0, 3'd0, 3'd0}, 3'd2, 1'b1, 4, 19, 5, 3'd1, 1'b0};
    tbl[5]  = '{1'b0, {3'd4, 3'd4, 3'd4, 3'd4}, 3'd4, 1'b0, 1, 3, 0, 3'd0, 1'b1};
    tbl[6]  = '{1'b1, {3'd5, 3'd5, 3'd5, 3'd5}, 3'd5, 1'b0, 1, 3, 0, 3'd5, 1'b0};
    tbl[7]  = '{1'b0, {3'd4, 3'd4, 3'd4, 3'd4}, 3'd4, 1'b0, 1, 3, 0, 3'd4, 1'b0};
    tbl[8]  = '{1'b0, {3'd3, 3'd3, 3'd3, 3'd3}, 3'd3, 1'b0, 1, 3, 0, 3'd3, 1'b0};
    tbl[9]  = '{1'b0, {3'd2, 3'd2, 3'd2, 3'd2}, 3'd2, 1'b0, 1, 3, 0, 3'd2, 1'b0};
    tbl[10] = '{1'b0, {3'd1, 3'd1, 3'd1, 3'd1}, 3'd1, 1'b0, 1, 3, 0, 3'd1, 1'b0};
    tbl[11] = '{1'b0, {3'd0, 3'd0, 3'd0, 3'd0}, 3'd0, 1'b0, 1, 3, 0, 3'd0, 1'b1};
    tbl[12] = '{1'b1, {3'd0, 3'd0, 3'd0, 3'd0}, 3'd0, 1'b0, 1, 3, 0, 3'd5, 1'b0};
    tbl[13] = '{1'b0, {3'd0, 3'd0, 3'd0, 3'd0}, 3'd1, 1'b1, 4, 19, 5, 3'd4, 1'b0};
    n_vec = 14;

    repeat (3) @(negedge clk);
    check("rst_valid", int'(valid), 0);
    check("rst_value", int'(value), 0);
    check("rst_remaining", int'(remaining), 6);
    check("rst_empty", int'(empty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_start", int'(rng_start), 0);
    check("rst_fallback", int'(fallback), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < n_vec; i++) begin
      if (tbl[i].clr) begin
        // Empty deck: a further draw must be ignored entirely.
        if (i == 6) begin
          start_cnt = 0;
          @(negedge clk);
          draw = 1'b1;
          @(negedge clk);
          draw = 1'b0;
          check("empty_draw_busy", int'(busy), 0);
          repeat (4) @(negedge clk);
          check("empty_draw_pulses", start_cnt, 0);
          check("empty_draw_busy_late", int'(busy), 0);
          check("empty_draw_remaining", int'(remaining), 0);
        end
        do_clear();
        check($sformatf("v%0d_clear_remaining", i), int'(remaining), 6);
        check($sformatf("v%0d_clear_empty", i), int'(empty), 0);
      end
      run_draw(tbl[i], i);
    end

    // Clear during the sample cycle aborts the draw; value is retained.
    rng_cur   = 12'd0;
    ridx      = 0;
    start_cnt = 0;
    @(negedge clk);
    draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    check("abort_start", int'(rng_start), 1);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("abort_valid", int'(valid), 0);
    check("abort_remaining", int'(remaining), 6);
    check("abort_busy", int'(busy), 0);
    check("abort_value_kept", int'(value), 1);
    nv = 0;
    for (int j = 0; j < 6; j++) begin
      if (valid) nv++;
      @(negedge clk);
    end
    check("abort_no_valid", nv, 0);
    check("abort_pulses", start_cnt, 1);
    run_draw('{1'b0, {3'd0, 3'd0, 3'd0, 3'd0}, 3'd0, 1'b0, 1, 3, 0, 3'd5, 1'b0}, 99);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/random_draw_ctrl.md
Name: random_draw_ctrl

Overview:
- Consumer side of the 3-bit random source, which returns a value 0..5 one cycle after it is sampled.
- Serves draw requests by pulsing the source's start input and reading the result one cycle later.
- Rejects values already drawn, so six draws return each of 0..5 exactly once (shuffled deck).
- Sits between the game-control FSM and the random source.

Parameters:
- P_RETRY_GAP, 3: idle cycles between a rejected sample and the next request, letting the source's free-running counter advance; legal range 1..15.
- P_MAX_RETRY, 4: number of rejected samples allowed per draw before falling back to the deterministic pick; legal range 1..15.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_draw  in  1  draw request; accepted only when o_busy=0 and o_empty=0
- i_clear  in  1  refill deck; highest priority
- o_rng_start  out  1  start pulse to the random source
- i_rng_value  in  3  random source output; valid the cycle after o_rng_start
- o_valid  out  1  one-cycle pulse: o_value holds the drawn card
- o_value  out  3  drawn card 0..5; holds its last value between draws
- o_busy  out  1  draw in progress
- o_remaining  out  3  undrawn cards, 6..0
- o_empty  out  1  o_remaining==0
- o_fallback  out  1  high with o_valid when the card came from the deterministic pick

Behaviour:
- Reset: clock is i_clk; reset is i_rst_n, asynchronous, active-low.
  - State S_IDLE; used mask 6'b0; o_remaining=6; o_empty=0.
  - o_value=0; o_valid=0; o_rng_start=0; o_busy=0; o_fallback=0.
  - Retry and gap counters = 0.
- State S_IDLE:
  - i_draw && !o_empty -> S_REQ; clear retry counter.
  - i_draw while o_empty is ignored: no pulse, no state change.
- State S_REQ: o_rng_start=1 for exactly this cycle -> S_SAMPLE.
- State S_SAMPLE: read i_rng_value; any value >=5 is treated as 5.
  - If mask[v]==0: set mask[v], o_value<=v, o_valid=1 next cycle, decrement o_remaining -> S_IDLE.
  - If mask[v]==1 and retry < P_MAX_RETRY-1: increment retry, load gap counter -> S_GAP.
  - If mask[v]==1 and retry == P_MAX_RETRY-1: -> S_FALLBACK.
- State S_GAP: o_rng_start=0; count down P_RETRY_GAP cycles -> S_REQ.
- State S_FALLBACK:
  - Pick the lowest index i with mask[i]==0, accept it as in S_SAMPLE, and assert o_fallback with o_valid.
  - This state always has a free card, because a draw is never started on an empty deck.
- o_busy=1 in every state except S_IDLE.
- Registered outputs, latency:
  - o_valid rises exactly 3 cycles after the i_draw cycle when the first sample is accepted (draw edge, S_REQ, S_SAMPLE, then o_valid).
  - Each rejection adds 2+P_RETRY_GAP cycles.
- o_remaining decrements by exactly 1 per o_valid; it never wraps below 0.
- o_empty is registered with o_remaining and rises on the same cycle as the sixth o_valid.
- i_clear, any state, any cycle:
  - Next cycle: mask=0, o_remaining=6, o_empty=0, state S_IDLE, o_valid=0, o_rng_start=0.
  - Aborts any in-flight draw with no o_valid.
  - o_value is retained.
- i_clear and i_draw in the same cycle: clear wins and the draw is dropped.
- i_draw while busy: ignored; there is no queueing.

Test Plan:
- Reset, then i_draw; bench returns 3 on the cycle after o_rng_start -> exactly one o_rng_start pulse; o_valid 3 cycles after i_draw with o_value=3, o_remaining=5, o_fallback=0.
- Draw 3 accepted, second draw returns 3 then 1 -> second o_rng_start exactly P_RETRY_GAP+2=5 cycles after the first; o_value=1, o_remaining=4.
- Bench always returns 0 after 0 is drawn -> 4 start pulses, then o_valid with o_value=1 (lowest unused) and o_fallback=1.
- Bench returns 7 and then 6 -> first accepted as 5; second is rejected as a duplicate of 5.
- Six draws returning 5,4,3,2,1,0 -> o_empty=1 on the 6th o_valid; a 7th i_draw produces no o_rng_start and o_busy stays 0.
- i_clear asserted the cycle after o_rng_start with 2 cards drawn -> no o_valid; next cycle o_remaining=6, S_IDLE; a following draw accepts a previously drawn value.
